// File: rtl/bin_to_bcd_serializer_pkg.sv
// Shared types and constants for the sequential binary-to-BCD serializer.
package bin_to_bcd_serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_EMIT
  } state_t;

  localparam int         BCD_W         = 4;
  localparam logic [3:0] DABBLE_THRESH = 4'd5;
  localparam logic [3:0] DABBLE_ADD    = 4'd3;

endpackage

// File: rtl/bcd_dabble_cell.sv
// One double-dabble correction cell: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_dabble_cell
  import bin_to_bcd_serializer_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adjusted
);

  assign adjusted = (digit >= DABBLE_THRESH) ? digit + DABBLE_ADD : digit;

endmodule

// File: rtl/bin_to_bcd_serializer.sv
// Shift-add-3 binary-to-BCD converter that streams digits MS-first, one per handshake.
// Optional macro LEADING_ZERO_SUPPRESS_EN: skip leading zero digits (value 0 still emits one 0).
module bin_to_bcd_serializer
  import bin_to_bcd_serializer_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int NDIG  = 3
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              bcd_out,
  output logic [$clog2(NDIG)-1:0] out_idx,
  output logic                    out_last
);

  localparam int IDX_W   = $clog2(NDIG);
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int BCD_TOT = BCD_W * NDIG;
  localparam int SR_W    = BIN_W + BCD_TOT;

  state_t            state;
  state_t            state_nxt;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_shift;
  logic [BCD_TOT-1:0] bcd_adj;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              alive;
  logic              accept;
  logic              conv_done;
  logic              out_hs;

`ifdef LEADING_ZERO_SUPPRESS_EN
  // Highest non-zero digit position; falls back to the units digit for value 0.
  function automatic logic [IDX_W-1:0] lead_idx(input logic [BCD_TOT-1:0] bcd);
    logic [IDX_W-1:0] top;
    top = '0;
    for (int d = 1; d < NDIG; d++) begin
      if (bcd[BCD_W*d +: BCD_W] != '0) top = IDX_W'(d);
    end
    return top;
  endfunction
`endif

  for (genvar g = 0; g < NDIG; g++) begin : g_cell
    bcd_dabble_cell u_cell (
      .digit   (sr[BIN_W + BCD_W*g +: BCD_W]),
      .adjusted(bcd_adj[BCD_W*g +: BCD_W])
    );
  end

  // Corrected BCD nibbles and the remaining binary bits shift left together.
  assign sr_shift  = SR_W'({bcd_adj, sr[BIN_W-1:0]} << 1);

  assign accept    = in_valid & in_ready;
  assign conv_done = (state == S_CONV) && (cnt == CNT_W'(BIN_W - 1));
  assign out_hs    = out_valid & out_ready;

  assign in_ready  = alive && (state == S_IDLE);
  assign out_valid = (state == S_EMIT);
  assign out_idx   = out_valid ? idx : '0;
  assign out_last  = out_valid && (idx == '0);
  assign bcd_out   = out_valid ? sr[BIN_W + BCD_W*int'(idx) +: BCD_W] : 4'd0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CONV;
      S_CONV:  if (conv_done) state_nxt = S_EMIT;
      S_EMIT:  if (out_hs && idx == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sr    <= '0;
      cnt   <= '0;
      idx   <= '0;
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            sr  <= {{BCD_TOT{1'b0}}, bin_in};
            cnt <= '0;
          end
        end
        S_CONV: begin
          sr  <= sr_shift;
          cnt <= cnt + 1'b1;
          if (conv_done) begin
`ifdef LEADING_ZERO_SUPPRESS_EN
            idx <= lead_idx(sr_shift[SR_W-1 -: BCD_TOT]);
`else
            idx <= IDX_W'(NDIG - 1);
`endif
          end
        end
        S_EMIT: begin
          if (out_hs && idx != '0) idx <= idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
